pool2x2_stride_collect: RTL and testbench

Eight-channel 2x2/stride-2 max-pool stage that consumes the packed 2x2 windows produced by the eight-lane 2x2 window line buffer, one window per channel per beat, in input raster order. It tracks the raster position of each beat for the frame width chosen by `sel`, keeps only windows anchored on odd row and odd column, and emits one signed int4 maximum per channel for each of them. It also flags the end of the frame. It sits between the window line buffer and the next layer's input stream.

---
 rtl/pool2x2_stride_collect.sv | 176 +++++++++++++++++
 tb/tb_pool2x2_stride_collect.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_stride_collect.sv
// ----------------------------------------------------------------------------
// pool2x2_stride_collect
// Eight-channel 2x2/stride-2 signed int4 max-pool over a raster stream of windows.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pool2x2_stride_collect #(
  parameter int LEN1 = 16,
  parameter int LEN2 = 14,
  parameter int LEN3 = 28,
  parameter int LEN4 = 56,
  parameter int LEN5 = 112,
  parameter int LEN6 = 224
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  sel,
  input  logic        in_valid,
  input  logic [15:0] ifm_win2x2_0,
  input  logic [15:0] ifm_win2x2_1,
  input  logic [15:0] ifm_win2x2_2,
  input  logic [15:0] ifm_win2x2_3,
  input  logic [15:0] ifm_win2x2_4,
  input  logic [15:0] ifm_win2x2_5,
  input  logic [15:0] ifm_win2x2_6,
  input  logic [15:0] ifm_win2x2_7,
  output logic [3:0]  pool_out_0,
  output logic [3:0]  pool_out_1,
  output logic [3:0]  pool_out_2,
  output logic [3:0]  pool_out_3,
  output logic [3:0]  pool_out_4,
  output logic [3:0]  pool_out_5,
  output logic [3:0]  pool_out_6,
  output logic [3:0]  pool_out_7,
  output logic        out_valid,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [7:0] c_len1 = 8'(LEN1);
  localparam logic [7:0] c_len2 = 8'(LEN2);
  localparam logic [7:0] c_len3 = 8'(LEN3);
  localparam logic [7:0] c_len4 = 8'(LEN4);
  localparam logic [7:0] c_len5 = 8'(LEN5);
  localparam logic [7:0] c_len6 = 8'(LEN6);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_row;
  logic [7:0]  r_col;
  logic [7:0]  r_w;
  logic [7:0]  w_sel_len;
  logic        w_sel_ok;
  logic        w_launch;
  logic        w_accept;
  logic        w_col_wrap;
  logic        w_last;
  logic        w_pick;
  logic [15:0] w_win [8];
  logic [3:0]  w_max [8];
  logic [3:0]  r_pool [8];
  logic        r_out_valid;

  function automatic logic [3:0] smax(input logic [3:0] a, input logic [3:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  always_comb begin
    w_sel_len = c_len1;
    case (sel)
      3'd0:    w_sel_len = c_len1;
      3'd1:    w_sel_len = c_len2;
      3'd2:    w_sel_len = c_len3;
      3'd3:    w_sel_len = c_len4;
      3'd4:    w_sel_len = c_len5;
      3'd5:    w_sel_len = c_len6;
      default: w_sel_len = c_len1;
    endcase
  end

  assign w_sel_ok   = (sel <= 3'd5);
  assign w_launch   = (r_state == S_IDLE) && start && w_sel_ok;
  assign w_accept   = (r_state == S_RUN) && in_valid;
  assign w_col_wrap = (r_col == r_w - 8'd1);
  assign w_last     = w_col_wrap && (r_row == r_w - 8'd1);
  // Only windows anchored on odd row and odd column are full, non-overlapping tiles.
  assign w_pick     = w_accept && r_row[0] && r_col[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_w   <= c_len1;
    end else if (w_launch) begin
      r_row <= '0;
      r_col <= '0;
      r_w   <= w_sel_len;
    end else if (w_accept) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= r_row + 8'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  assign w_win[0] = ifm_win2x2_0;
  assign w_win[1] = ifm_win2x2_1;
  assign w_win[2] = ifm_win2x2_2;
  assign w_win[3] = ifm_win2x2_3;
  assign w_win[4] = ifm_win2x2_4;
  assign w_win[5] = ifm_win2x2_5;
  assign w_win[6] = ifm_win2x2_6;
  assign w_win[7] = ifm_win2x2_7;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
      assign w_max[gi] = smax(smax(w_win[gi][15:12], w_win[gi][11:8]),
                              smax(w_win[gi][7:4],   w_win[gi][3:0]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      for (int i = 0; i < 8; i++) r_pool[i] <= '0;
    end else begin
      r_out_valid <= w_pick;
      if (w_pick) begin
        for (int i = 0; i < 8; i++) r_pool[i] <= w_max[i];
      end
    end
  end

  assign pool_out_0 = r_pool[0];
  assign pool_out_1 = r_pool[1];
  assign pool_out_2 = r_pool[2];
  assign pool_out_3 = r_pool[3];
  assign pool_out_4 = r_pool[4];
  assign pool_out_5 = r_pool[5];
  assign pool_out_6 = r_pool[6];
  assign pool_out_7 = r_pool[7];
  assign out_valid  = r_out_valid;
  assign frame_done = (r_state == S_DONE);
  assign busy       = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_pool2x2_stride_collect.sv
// ----------------------------------------------------------------------------
// tb_pool2x2_stride_collect
// Scoreboard bench: image-level reference model vs. pooled output stream.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pool2x2_stride_collect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  sel;
  logic        in_valid;
  logic [15:0] win [8];
  logic [3:0]  po [8];
  logic        out_valid;
  logic        frame_done;
  logic        busy;

  always #5 clk = ~clk;

  pool2x2_stride_collect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sel          (sel),
    .in_valid     (in_valid),
    .ifm_win2x2_0 (win[0]),
    .ifm_win2x2_1 (win[1]),
    .ifm_win2x2_2 (win[2]),
    .ifm_win2x2_3 (win[3]),
    .ifm_win2x2_4 (win[4]),
    .ifm_win2x2_5 (win[5]),
    .ifm_win2x2_6 (win[6]),
    .ifm_win2x2_7 (win[7]),
    .pool_out_0   (po[0]),
    .pool_out_1   (po[1]),
    .pool_out_2   (po[2]),
    .pool_out_3   (po[3]),
    .pool_out_4   (po[4]),
    .pool_out_5   (po[5]),
    .pool_out_6   (po[6]),
    .pool_out_7   (po[7]),
    .out_valid    (out_valid),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  typedef struct {
    logic [31:0] vals;
    bit          last;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          out_cnt = 0;
  int          done_cnt = 0;
  int          lens[6] = '{16, 14, 28, 56, 112, 224};
  logic [15:0] cwin [8];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int n);
    return (n >= 8) ? n - 16 : n;
  endfunction

  // Synthetic image pixel for channel ch at (r, c), as a raw 4-bit code.
  function automatic int pix(input int ch, input int r, input int c, input int seed);
    return ((r * 37 + c * 11 + ch * 53 + seed) ^ (r * c * 7) ^ (seed >> 3)) & 15;
  endfunction

  function automatic logic [31:0] packed_out();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = po[i];
    return v;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin : monitor
    logic [31:0] last_exp;
    bit          prev_valid;
    exp_t        e;
    last_exp   = '0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_exp   = '0;
        prev_valid = 1'b0;
      end else begin
        if (out_valid) begin
          out_cnt++;
          check("out_spacing", prev_valid, 0);
          if (q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            e = q.pop_front();
            check("pool_out", packed_out(), e.vals);
            check("frame_done_with_last", frame_done, e.last);
            last_exp = e.vals;
          end
        end else begin
          check("pool_hold", packed_out(), last_exp);
          if (frame_done) check("frame_done_without_out", 1, 0);
        end
        if (frame_done) done_cnt++;
        prev_valid = out_valid;
      end
    end
  end

  task automatic run_frame(input int s, input int mode, input int bub_pct, input bit toggle,
                           input int abort_at, input bit poke, input int seed);
    int   w, nb, k, r, c, base_out, base_done, i0, j0, m, f;
    bit   v, ph;
    exp_t e;
    w = lens[s];
    nb = w * w;
    k = 0;
    ph = 1'b1;
    base_out = out_cnt;
    base_done = done_cnt;
    start = 1'b1;
    sel = 3'(s);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while (k < nb) begin
      if (k == abort_at) begin
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_frame_done", frame_done, 0);
        check("abort_busy", busy, 0);
        check("abort_pool_out", packed_out(), 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_frame_done", done_cnt - base_done, 0);
        check("abort_queue_empty", q.size(), 0);
        q.delete();
        return;
      end
      if (toggle) begin
        v = ph;
        ph = !ph;
      end else begin
        v = ($urandom_range(99) >= bub_pct);
      end
      if (toggle && k == nb / 2) sel = 3'd3;
      if (poke && $urandom_range(15) == 0) begin
        start = 1'b1;
        sel = 3'($urandom_range(5));
      end else begin
        start = 1'b0;
      end
      in_valid = v;
      if (v) begin
        r = k / w;
        c = k % w;
        for (int ch = 0; ch < 8; ch++) begin
          if (mode == 0) begin
            win[ch] = cwin[ch];
          end else if (r > 0 && c > 0) begin
            win[ch] = {4'(pix(ch, r-1, c-1, seed)), 4'(pix(ch, r-1, c, seed)),
                       4'(pix(ch, r, c-1, seed)),   4'(pix(ch, r, c, seed))};
          end else begin
            win[ch] = 16'($urandom);
          end
        end
        if (r % 2 == 1 && c % 2 == 1) begin
          i0 = (r - 1) / 2;
          j0 = (c - 1) / 2;
          for (int ch = 0; ch < 8; ch++) begin
            m = -100;
            for (int t = 0; t < 4; t++) begin
              if (mode == 0) f = sx((cwin[ch] >> (4 * t)) & 15);
              else           f = sx(pix(ch, 2*i0 + t/2, 2*j0 + t%2, seed));
              if (f > m) m = f;
            end
            e.vals[4*ch +: 4] = 4'(m);
          end
          e.last = (r == w - 1) && (c == w - 1);
          q.push_back(e);
        end
        k++;
      end else begin
        for (int ch = 0; ch < 8; ch++) win[ch] = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("frame_out_count", out_cnt - base_out, (w / 2) * (w / 2));
    check("frame_done_count", done_cnt - base_done, 1);
    check("busy_after_frame", busy, 0);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin : stimulus
    int base_out;
    int seed;
    rst_n = 1'b0;
    start = 1'b0;
    sel = 3'd0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) win[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pool_out", packed_out(), 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) cwin[i] = 16'h3E78;
    run_frame(1, 0, 0, 1'b0, -1, 1'b0, 0);

    foreach (lens[kk]) begin
      if (kk == 0 || kk == 5) begin
        for (int i = 0; i < 8; i++) cwin[i] = 16'h8888;
        cwin[kk] = 16'h8F9A;
        run_frame(0, 0, 0, 1'b0, -1, 1'b0, 0);
      end
    end

    seed = int'($urandom_range(1000));
    run_frame(0, 1, 0, 1'b1, -1, 1'b0, seed);

    run_frame(0, 1, 0, 1'b0, 100, 1'b0, seed + 1);
    run_frame(0, 1, 0, 1'b0, -1, 1'b0, seed + 2);

    base_out = out_cnt;
    start = 1'b1;
    sel = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    check("reserved_sel_busy", busy, 0);
    in_valid = 1'b1;
    repeat (300) begin
      for (int i = 0; i < 8; i++) win[i] = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("reserved_sel_no_out", out_cnt - base_out, 0);
    check("reserved_sel_busy_end", busy, 0);

    run_frame(2, 1, 30, 1'b0, -1, 1'b1, int'($urandom_range(5000)));
    run_frame(3, 1, 20, 1'b0, -1, 1'b1, int'($urandom_range(5000)));
    run_frame(5, 1, 0, 1'b0, -1, 1'b0, int'($urandom_range(5000)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
